// File: rtl/clocked_split_n.sv
// N-way valid/ready split with per-output FIFOs.
// Out-of-range selects are consumed, flagged and counted.
module clocked_split_n #(
  parameter int WIDTH = 8,
  parameter int NOUT  = 4,
  parameter int SEL_W = 2,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      x_data,
  input  logic                  x_valid,
  output logic                  x_ready,
  input  logic [SEL_W-1:0]      c_sel,
  input  logic                  c_valid,
  output logic                  c_ready,
  output logic [NOUT*WIDTH-1:0] y_data,
  output logic [NOUT-1:0]       y_valid,
  input  logic [NOUT-1:0]       y_ready,
  output logic                  err_sel,
  output logic [CNT_W-1:0]      drop_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SEL_W:0]   sel_x;
  logic             bad;
  logic             fire;
  logic [NOUT-1:0]  hit;
  logic [NOUT-1:0]  full;
  logic [NOUT-1:0]  push;
  logic [NOUT-1:0]  pop;

  assign sel_x = {1'b0, c_sel};
  assign bad   = sel_x >= (SEL_W+1)'(NOUT);

  // Ready depends only on inputs and registered counts.
  assign fire = reset & x_valid & c_valid
              & (bad | ~|(hit & full));

  assign x_ready = fire;
  assign c_ready = fire;

  for (genvar i = 0; i < NOUT; i++) begin : g_out
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW:0]      cnt;

    assign hit[i]  = (c_sel == SEL_W'(i));
    assign full[i] = (cnt == (PW+1)'(DEPTH));
    assign push[i] = fire & hit[i];
    assign pop[i]  = y_valid[i] & y_ready[i];

    assign y_valid[i] = |cnt;
    assign y_data[i*WIDTH +: WIDTH] = mem[rd_ptr];

    always_ff @(posedge clk) begin
      if (push[i]) mem[wr_ptr] <= x_data;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push[i]) wr_ptr <= wr_ptr + PW'(1);
        if (pop[i])  rd_ptr <= rd_ptr + PW'(1);
        case ({push[i], pop[i]})
          2'b10:   cnt <= cnt + (PW+1)'(1);
          2'b01:   cnt <= cnt - (PW+1)'(1);
          default: cnt <= cnt;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_sel  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      err_sel <= fire & bad;
      if (fire & bad & ~&drop_cnt)
        drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule
